// File: rtl/rca_pipelined_8bit.sv
// Pipelined 8-bit ripple-carry adder, NUM_STAGES segments of 8/NUM_STAGES bits.
// Define RCA_PIPE_VALID_EN to add an in_valid/out_valid flag pipeline.
module rca_pipelined_8bit #(
   parameter int NUM_STAGES = 2
) (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c,
   input  logic       clk,
   output logic [7:0] sum,
   output logic       cout,
   input  logic       rst
`ifdef RCA_PIPE_VALID_EN
   ,
   input  logic       in_valid,
   output logic       out_valid
`endif
);

   localparam int W = 8 / NUM_STAGES;

   if (NUM_STAGES != 1 && NUM_STAGES != 2 &&
       NUM_STAGES != 4 && NUM_STAGES != 8) begin : g_bad
      $error("NUM_STAGES must be 1, 2, 4 or 8");
   end

   function automatic logic [W:0] ripple(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         ci
   );
      logic [W-1:0] s;
      logic         cy;
      cy = ci;
      s  = '0;
      for (int i = 0; i < W; i++) begin
         s[i] = x[i] ^ y[i] ^ cy;
         cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
      return {cy, s};
   endfunction

   for (genvar k = 0; k < NUM_STAGES; k++) begin : stg
      logic [W-1:0]       sa;
      logic [W-1:0]       sb;
      logic               si;
      logic [W:0]         res;
      logic [(k+1)*W-1:0] sr;
      logic               co;
`ifdef RCA_PIPE_VALID_EN
      logic               vi;
      logic               v;
`endif

      if (k == 0) begin : g_in
         assign sa = a[W-1:0];
         assign sb = b[W-1:0];
         assign si = c;
`ifdef RCA_PIPE_VALID_EN
         assign vi = in_valid;
`endif
      end else begin : g_in
         assign sa = stg[k-1].g_fw.fa[W-1:0];
         assign sb = stg[k-1].g_fw.fb[W-1:0];
         assign si = stg[k-1].co;
`ifdef RCA_PIPE_VALID_EN
         assign vi = stg[k-1].v;
`endif
      end

      assign res = ripple(sa, sb, si);

      // Upper operand segments not yet consumed ride along with the carry.
      if (k < NUM_STAGES - 1) begin : g_fw
         logic [8-(k+1)*W-1:0] fa;
         logic [8-(k+1)*W-1:0] fb;
         if (k == 0) begin : g_src
            always_ff @(posedge clk) begin
               if (rst) begin
                  fa <= '0;
                  fb <= '0;
               end else begin
                  fa <= a[7:W];
                  fb <= b[7:W];
               end
            end
         end else begin : g_src
            always_ff @(posedge clk) begin
               if (rst) begin
                  fa <= '0;
                  fb <= '0;
               end else begin
                  fa <= stg[k-1].g_fw.fa[8-k*W-1:W];
                  fb <= stg[k-1].g_fw.fb[8-k*W-1:W];
               end
            end
         end
      end

      if (k == 0) begin : g_sum
         always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= res[W-1:0];
         end
      end else begin : g_sum
         always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= {res[W-1:0], stg[k-1].sr};
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            co <= 1'b0;
`ifdef RCA_PIPE_VALID_EN
            v  <= 1'b0;
`endif
         end else begin
            co <= res[W];
`ifdef RCA_PIPE_VALID_EN
            v  <= vi;
`endif
         end
      end
   end

   assign sum  = stg[NUM_STAGES-1].sr;
   assign cout = stg[NUM_STAGES-1].co;
`ifdef RCA_PIPE_VALID_EN
   assign out_valid = stg[NUM_STAGES-1].v;
`endif

endmodule

// File: tb/tb_rca_pipelined_8bit.sv
// Bench for rca_pipelined_8bit: four instances (1,2,4,8 stages) share stimulus;
// a queue of expected results is indexed by each instance's latency.
module tb_rca_pipelined_8bit;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       c;
   logic       in_valid;

   logic [7:0] s1, s2, s4, s8;
   logic       c1, c2, c4, c8;
   logic       v1, v2, v4, v8;

   int nchk;
   int nfail;
   int n;
   logic [9:0] sbq[$];

`ifdef RCA_PIPE_VALID_EN
   rca_pipelined_8bit #(.NUM_STAGES(1)) u1 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s1), .cout(c1), .rst(rst), .in_valid(in_valid), .out_valid(v1));
   rca_pipelined_8bit #(.NUM_STAGES(2)) u2 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s2), .cout(c2), .rst(rst), .in_valid(in_valid), .out_valid(v2));
   rca_pipelined_8bit #(.NUM_STAGES(4)) u4 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s4), .cout(c4), .rst(rst), .in_valid(in_valid), .out_valid(v4));
   rca_pipelined_8bit #(.NUM_STAGES(8)) u8 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s8), .cout(c8), .rst(rst), .in_valid(in_valid), .out_valid(v8));
`else
   rca_pipelined_8bit #(.NUM_STAGES(1)) u1 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s1), .cout(c1), .rst(rst));
   rca_pipelined_8bit #(.NUM_STAGES(2)) u2 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s2), .cout(c2), .rst(rst));
   rca_pipelined_8bit #(.NUM_STAGES(4)) u4 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s4), .cout(c4), .rst(rst));
   rca_pipelined_8bit #(.NUM_STAGES(8)) u8 (.a(a), .b(b), .c(c), .clk(clk),
      .sum(s8), .cout(c8), .rst(rst));
   assign v1 = 1'b0;
   assign v2 = 1'b0;
   assign v4 = 1'b0;
   assign v8 = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [9:0] obs,
                      input logic [9:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] expect_for(input int st);
      logic [9:0] e;
      if (n >= st) e = sbq[sbq.size() - st];
      else         e = '0;
`ifndef RCA_PIPE_VALID_EN
      e[9] = 1'b0;
`endif
      return e;
   endfunction

   task automatic step(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic ir, input logic iv);
      logic [8:0] r;
      a = ia;
      b = ib;
      c = ic;
      rst = ir;
      in_valid = iv;
      @(posedge clk);
      #1;
      if (ir) begin
         n = 0;
         sbq.delete();
      end else begin
         r = 9'(ia) + 9'(ib) + 9'(ic);
         sbq.push_back({iv, r});
         n++;
         if (sbq.size() > 8) void'(sbq.pop_front());
      end
      chk("ns1", {v1, c1, s1}, expect_for(1));
      chk("ns2", {v2, c2, s2}, expect_for(2));
      chk("ns4", {v4, c4, s4}, expect_for(4));
      chk("ns8", {v8, c8, s8}, expect_for(8));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      nchk  = 0;
      nfail = 0;
      n     = 0;
      in_valid = 1'b0;

      // reset, then a single add
      step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      chk("rst_s2", {v2, c2, s2}, 10'h000);
      step(8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
      idle(8);

      // back-to-back stream
      step(8'd3,  8'd3,  1'b1, 1'b0, 1'b1);
      step(8'd7,  8'd7,  1'b1, 1'b0, 1'b0);
      step(8'd4,  8'd10, 1'b1, 1'b0, 1'b1);
      step(8'd5,  8'd9,  1'b1, 1'b0, 1'b1);
      step(8'd2,  8'd5,  1'b0, 1'b0, 1'b0);
      step(8'd13, 8'd1,  1'b1, 1'b0, 1'b1);

      // carries across segment boundaries and full wrap
      step(8'd15,  8'd1,   1'b0, 1'b0, 1'b1);
      step(8'h0F,  8'h00,  1'b1, 1'b0, 1'b0);
      step(8'd255, 8'd1,   1'b0, 1'b0, 1'b1);
      step(8'd255, 8'd255, 1'b1, 1'b0, 1'b1);
      step(8'h80,  8'h80,  1'b0, 1'b0, 1'b1);
      step(8'h55,  8'hAA,  1'b1, 1'b0, 1'b0);
      idle(8);

      // some random traffic
      for (int i = 0; i < 40; i++)
         step(8'($urandom), 8'($urandom), 1'($urandom),
              1'b0, 1'($urandom));
      idle(2);

      // reset mid-stream: nothing from before reset may emerge
      step(8'd100, 8'd27, 1'b1, 1'b0, 1'b1);
      step(8'd200, 8'd99, 1'b0, 1'b0, 1'b1);
      step(8'd250, 8'd10, 1'b1, 1'b0, 1'b1);
      step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      chk("midrst_s8", {v8, c8, s8}, 10'h000);
      idle(9);
      step(8'd9, 8'd8, 1'b1, 1'b0, 1'b1);
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
